// File: rtl/xsleenacore_mcu_latch.sv
// Main-CPU <-> MCU mailbox: two 8-bit latches with pending/ready handshake flags,
// plus an MCU reset pulse generator that the main CPU can (re)trigger.
module xsleenacore_mcu_latch #(
    parameter int unsigned RESET_CYCLES = 16
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       W3A0En,
    input  logic       R3A04n,
    input  logic       R3A06n,
    input  logic [7:0] DB_in,
    output logic [7:0] MCU_TO_MAIN,
    input  logic [7:0] MCU_PA_in,
    output logic [7:0] MCU_PA_out,
    input  logic       MCU_RDn,
    input  logic       MCU_WRn,
    output logic       P5READn,
    output logic       P5ACCEPTn,
    output logic       MCU_IRQn,
    output logic       MCU_RESETn
);

    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [7:0] RELOAD = RESET_CYCLES[7:0];

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic       w3a0en_p1, r3a04n_p1, r3a06n_p1, mcu_rdn_p1, mcu_wrn_p1;
    logic [7:0] main_stage, mcu_stage;
    logic [7:0] pa_out_q, to_main_q;
    logic       main_pending, mcu_ready;
    logic       main_pending_d, mcu_ready_d;

    logic       main_wr_rise, main_rd_rise, mcu_rst_fall, mcu_rd_rise, mcu_wr_rise;
    logic       in_hold;

    assign main_wr_rise = ~w3a0en_p1 & W3A0En;
    assign main_rd_rise = ~r3a04n_p1 & R3A04n;
    assign mcu_rst_fall = r3a06n_p1 & ~R3A06n;
    assign in_hold      = (state_q == HOLD);
    // MCU-side strobes are dead while the MCU itself is held in reset.
    assign mcu_rd_rise  = ~mcu_rdn_p1 & MCU_RDn & ~in_hold;
    assign mcu_wr_rise  = ~mcu_wrn_p1 & MCU_WRn & ~in_hold;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mcu_rst_fall) begin
            state_d = HOLD;
            cnt_d   = RELOAD;
        end else if (in_hold) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
                state_d = RUN;
                cnt_d   = 8'd0;
            end
        end
    end

    // A set in the same cycle as any clear keeps the flag set.
    always_comb begin
        main_pending_d = main_pending;
        mcu_ready_d    = mcu_ready;
        if (mcu_rd_rise || mcu_rst_fall) main_pending_d = 1'b0;
        if (main_wr_rise)                main_pending_d = 1'b1;
        if (main_rd_rise || mcu_rst_fall) mcu_ready_d   = 1'b0;
        if (mcu_wr_rise)                  mcu_ready_d   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q      <= HOLD;
            cnt_q        <= RELOAD;
            w3a0en_p1    <= 1'b1;
            r3a04n_p1    <= 1'b1;
            r3a06n_p1    <= 1'b1;
            mcu_rdn_p1   <= 1'b1;
            mcu_wrn_p1   <= 1'b1;
            main_stage   <= 8'hFF;
            mcu_stage    <= 8'hFF;
            pa_out_q     <= 8'hFF;
            to_main_q    <= 8'hFF;
            main_pending <= 1'b0;
            mcu_ready    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            w3a0en_p1    <= W3A0En;
            r3a04n_p1    <= R3A04n;
            r3a06n_p1    <= R3A06n;
            mcu_rdn_p1   <= MCU_RDn;
            mcu_wrn_p1   <= MCU_WRn;
            main_pending <= main_pending_d;
            mcu_ready    <= mcu_ready_d;
            if (!W3A0En)  main_stage <= DB_in;
            if (!MCU_WRn) mcu_stage  <= MCU_PA_in;
            if (main_wr_rise) pa_out_q  <= main_stage;
            if (mcu_wr_rise)  to_main_q <= mcu_stage;
        end
    end

    assign MCU_PA_out  = pa_out_q;
    assign MCU_TO_MAIN = to_main_q;
    assign P5ACCEPTn   = main_pending;
    assign MCU_IRQn    = ~main_pending;
    assign P5READn     = ~mcu_ready;
    assign MCU_RESETn  = (state_q == RUN);

endmodule

// File: tb/tb_xsleenacore_mcu_latch.sv
// Directed bench for the MCU mailbox latch: per-cycle reference model compare
// plus hand-computed expectations for each scenario.
module tb_xsleenacore_mcu_latch;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       W3A0En = 1'b1, R3A04n = 1'b1, R3A06n = 1'b1;
    logic       MCU_RDn = 1'b1, MCU_WRn = 1'b1;
    logic [7:0] DB_in = 8'h00, MCU_PA_in = 8'h00;
    logic [7:0] MCU_TO_MAIN, MCU_PA_out;
    logic       P5READn, P5ACCEPTn, MCU_IRQn, MCU_RESETn;

    int total = 0;
    int passed = 0;

    xsleenacore_mcu_latch #(.RESET_CYCLES(N)) dut (
        .clk(clk), .RST(RST), .W3A0En(W3A0En), .R3A04n(R3A04n), .R3A06n(R3A06n),
        .DB_in(DB_in), .MCU_TO_MAIN(MCU_TO_MAIN), .MCU_PA_in(MCU_PA_in),
        .MCU_PA_out(MCU_PA_out), .MCU_RDn(MCU_RDn), .MCU_WRn(MCU_WRn),
        .P5READn(P5READn), .P5ACCEPTn(P5ACCEPTn), .MCU_IRQn(MCU_IRQn),
        .MCU_RESETn(MCU_RESETn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Reference model: mailbox contents, flags and "cycles of MCU reset remaining".
    logic [7:0] m_pa, m_tm, m_sm, m_ss;
    logic       m_mp, m_mr, m_valid = 1'b0;
    int         m_rem;
    logic       pw, pr4, pr6, prd, pwr;

    always @(posedge clk) begin
        if (RST) begin
            m_pa = 8'hFF; m_tm = 8'hFF; m_sm = 8'hFF; m_ss = 8'hFF;
            m_mp = 1'b0; m_mr = 1'b0; m_rem = N; m_valid = 1'b1;
            pw = 1; pr4 = 1; pr6 = 1; prd = 1; pwr = 1;
        end else begin
            bit hold, w_up, r4_up, r6_down, rd_up, wr_up;
            hold    = (m_rem > 0);
            w_up    = !pw && W3A0En;
            r4_up   = !pr4 && R3A04n;
            r6_down = pr6 && !R3A06n;
            rd_up   = !prd && MCU_RDn && !hold;
            wr_up   = !pwr && MCU_WRn && !hold;
            if (w_up) m_pa = m_sm;
            if (!W3A0En) m_sm = DB_in;
            if (wr_up) m_tm = m_ss;
            if (!MCU_WRn) m_ss = MCU_PA_in;
            m_mp = w_up  ? 1'b1 : ((rd_up || r6_down) ? 1'b0 : m_mp);
            m_mr = wr_up ? 1'b1 : ((r4_up || r6_down) ? 1'b0 : m_mr);
            if (r6_down) m_rem = N;
            else if (m_rem > 0) m_rem = m_rem - 1;
            pw = W3A0En; pr4 = R3A04n; pr6 = R3A06n; prd = MCU_RDn; pwr = MCU_WRn;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pa_out",   MCU_PA_out,  m_pa);
            chk("model_to_main",  MCU_TO_MAIN, m_tm);
            chk("model_accept_n", {7'd0, P5ACCEPTn},  {7'd0, m_mp});
            chk("model_irq_n",    {7'd0, MCU_IRQn},   {7'd0, ~m_mp});
            chk("model_read_n",   {7'd0, P5READn},    {7'd0, ~m_mr});
            chk("model_resetn",   {7'd0, MCU_RESETn}, {7'd0, 1'(m_rem == 0)});
        end
    end

    // Length of the most recent MCU reset-low run, counting only cycles with RST low.
    int low_run = 0;
    int last_low = 0;
    always @(negedge clk) begin
        if (RST) low_run = 0;
        else if (MCU_RESETn === 1'b0) low_run++;
        else if (low_run != 0) begin
            last_low = low_run;
            low_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_release(input string name, input int exp_len);
        int k;
        k = 0;
        while (MCU_RESETn !== 1'b1 && k < 300) begin
            tick(1);
            k++;
        end
        if (MCU_RESETn !== 1'b1) begin
            $display("FAIL %s_timeout actual=%0d expected=<300 cycles", name, k);
            total++;
        end else begin
            @(negedge clk);
            #1;
            chk(name, 8'(last_low), 8'(exp_len));
        end
    endtask

    initial begin
        tick(2);
        chk("rst_pa_out",   MCU_PA_out, 8'hFF);
        chk("rst_to_main",  MCU_TO_MAIN, 8'hFF);
        chk("rst_accept_n", {7'd0, P5ACCEPTn}, 8'h00);
        chk("rst_read_n",   {7'd0, P5READn}, 8'h01);
        chk("rst_irq_n",    {7'd0, MCU_IRQn}, 8'h01);
        chk("rst_resetn",   {7'd0, MCU_RESETn}, 8'h00);
        RST = 1'b0;
        wait_release("por_low_len", N);

        // main write of 5A held for three cycles
        W3A0En = 1'b0; DB_in = 8'h5A; tick(3);
        chk("pre_wr_accept_n", {7'd0, P5ACCEPTn}, 8'h00);
        W3A0En = 1'b1; DB_in = 8'h00; tick(1);
        chk("wr_pa_out",   MCU_PA_out, 8'h5A);
        chk("wr_accept_n", {7'd0, P5ACCEPTn}, 8'h01);
        chk("wr_irq_n",    {7'd0, MCU_IRQn}, 8'h00);
        MCU_RDn = 1'b0; tick(1); MCU_RDn = 1'b1; tick(1);
        chk("rd_accept_n", {7'd0, P5ACCEPTn}, 8'h00);
        chk("rd_irq_n",    {7'd0, MCU_IRQn}, 8'h01);
        chk("rd_pa_kept",  MCU_PA_out, 8'h5A);

        // MCU reply C3
        MCU_PA_in = 8'hC3; MCU_WRn = 1'b0; tick(1); MCU_WRn = 1'b1; tick(1);
        chk("reply_to_main", MCU_TO_MAIN, 8'hC3);
        chk("reply_read_n",  {7'd0, P5READn}, 8'h00);
        R3A04n = 1'b0; tick(1); R3A04n = 1'b1; tick(1);
        chk("ack_read_n",  {7'd0, P5READn}, 8'h01);
        chk("ack_to_main", MCU_TO_MAIN, 8'hC3);

        // write rise coincides with MCU read rise: set wins
        W3A0En = 1'b0; MCU_RDn = 1'b0; DB_in = 8'hA7; tick(1);
        W3A0En = 1'b1; MCU_RDn = 1'b1; tick(1);
        chk("same_accept_n", {7'd0, P5ACCEPTn}, 8'h01);
        chk("same_pa_out",   MCU_PA_out, 8'hA7);

        // both flags set, then MCU reset request
        MCU_PA_in = 8'h3C; MCU_WRn = 1'b0; tick(1); MCU_WRn = 1'b1; tick(1);
        chk("both_read_n", {7'd0, P5READn}, 8'h00);
        R3A06n = 1'b0; tick(1); R3A06n = 1'b1; tick(1);
        chk("hold_accept_n", {7'd0, P5ACCEPTn}, 8'h00);
        chk("hold_read_n",   {7'd0, P5READn}, 8'h01);
        chk("hold_resetn",   {7'd0, MCU_RESETn}, 8'h00);
        MCU_PA_in = 8'h99; MCU_WRn = 1'b0; tick(1); MCU_WRn = 1'b1; tick(1);
        chk("hold_wr_read_n",  {7'd0, P5READn}, 8'h01);
        chk("hold_wr_to_main", MCU_TO_MAIN, 8'h3C);
        wait_release("hold_low_len", N);

        // retrigger at cycle 10 of hold
        R3A06n = 1'b0; tick(1); R3A06n = 1'b1; tick(1);
        tick(8);
        R3A06n = 1'b0; tick(1); R3A06n = 1'b1;
        wait_release("retrig_low_len", 10 + N);

        // reset request coincides with main write rise
        W3A0En = 1'b0; DB_in = 8'h11; tick(1);
        W3A0En = 1'b1; R3A06n = 1'b0; tick(1); R3A06n = 1'b1; tick(1);
        chk("r6w_accept_n", {7'd0, P5ACCEPTn}, 8'h01);
        chk("r6w_pa_out",   MCU_PA_out, 8'h11);
        chk("r6w_resetn",   {7'd0, MCU_RESETn}, 8'h00);
        wait_release("r6w_low_len", N);

        // RST in the middle of a write
        W3A0En = 1'b0; DB_in = 8'hEE; tick(1); W3A0En = 1'b1; tick(1);
        W3A0En = 1'b0; DB_in = 8'h44; tick(1);
        RST = 1'b1; tick(1);
        chk("midrst_pa_out",   MCU_PA_out, 8'hFF);
        chk("midrst_accept_n", {7'd0, P5ACCEPTn}, 8'h00);
        chk("midrst_to_main",  MCU_TO_MAIN, 8'hFF);
        W3A0En = 1'b1; tick(1);
        RST = 1'b0;
        wait_release("midrst_low_len", N);
        tick(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
